// File: rtl/mem_resp_pkg.sv
// Shared types and widths for the CPU memory-port responder.
// The CPU bus widths live here so that every file sees one definition of them.
package mem_resp_pkg;

  localparam int ADDR_BITS = 32;
  localparam int DATA_BITS = 32;
  localparam int WEB_BITS  = 4;
  localparam int SRAM_AW   = 14;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } resp_state_e;

  typedef enum logic [1:0] {
    ACC_RD,
    ACC_WR,
    ACC_ERR
  } acc_type_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/resp_lat_cnt.sv
// Saturating up-counter that measures SRAM access latency.
// hit_o flags the cycle in which the count equals the programmed terminal value.
module resp_lat_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic [W-1:0] cnt_o,
  output logic         hit_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Holding at all-ones keeps a stuck access from aliasing back to zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign hit_o = (cnt_q == term_i);

endmodule

// File: rtl/mem_port_responder.sv
// Slave responder for one CPU memory port: accepts a req/read/write request,
// stalls the CPU while a fixed-latency SRAM access runs, then returns read data.
module mem_port_responder
  import mem_resp_pkg::*;
#(
  parameter int READ_LAT  = 2,
  parameter int WRITE_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_i,
  input  logic                 read_i,
  input  logic                 write_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  input  logic [WEB_BITS-1:0]  web_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  output logic                 wait_o,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 err_o,
  output logic                 sram_cs_o,
  output logic                 sram_oe_o,
  output logic [WEB_BITS-1:0]  sram_web_o,
  output logic [SRAM_AW-1:0]   sram_a_o,
  output logic [DATA_BITS-1:0] sram_di_o,
  input  logic [DATA_BITS-1:0] sram_do_i
);

  localparam int CNT_MAX = max2(READ_LAT + 1, WRITE_LAT);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  resp_state_e          state_q;
  acc_type_e            acc_q;
  logic [DATA_BITS-1:0] rdata_q;
  logic                 err_q;
  logic                 cs_q;
  logic                 oe_q;
  logic [WEB_BITS-1:0]  web_q;
  logic [SRAM_AW-1:0]   a_q;
  logic [DATA_BITS-1:0] di_q;

  logic [CNT_W-1:0]     cnt_term;
  logic [CNT_W-1:0]     cnt_unused;
  logic                 cnt_hit;
  logic                 addr_unused;

  assign addr_unused = ^{addr_i[ADDR_BITS-1:SRAM_AW+2], addr_i[1:0]};

  // Count 0 is the strobe cycle: a read spends READ_LAT+1 cycles in BUSY, a write WRITE_LAT.
  assign cnt_term = (acc_q == ACC_RD) ? CNT_W'(READ_LAT) : CNT_W'(WRITE_LAT - 1);

  resp_lat_cnt #(
    .W (CNT_W)
  ) u_lat_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (state_q != BUSY),
    .en_i   (state_q == BUSY),
    .term_i (cnt_term),
    .cnt_o  (cnt_unused),
    .hit_o  (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= ACC_RD;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cs_q    <= 1'b0;
      oe_q    <= 1'b0;
      web_q   <= '1;
      a_q     <= '0;
      di_q    <= '0;
    end else begin
      cs_q  <= 1'b0;
      err_q <= 1'b0;
      web_q <= '1;
      case (state_q)
        IDLE: begin
          if (req_i) begin
            a_q  <= addr_i[SRAM_AW+1:2];
            di_q <= wdata_i;
            if (read_i == write_i) begin
              // Ambiguous request: complete the handshake without touching the SRAM.
              acc_q   <= ACC_ERR;
              err_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              acc_q   <= read_i ? ACC_RD : ACC_WR;
              cs_q    <= 1'b1;
              oe_q    <= read_i;
              web_q   <= read_i ? {WEB_BITS{1'b1}} : web_i;
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt_hit) begin
            oe_q    <= 1'b0;
            state_q <= DONE;
            if (acc_q == ACC_RD) begin
              rdata_q <= sram_do_i;
            end
          end
        end
        // The CPU's req is still high for the finished access, so it is ignored here.
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wait_o     = rst_n && (((state_q == IDLE) && req_i) || (state_q == BUSY));
  assign rdata_o    = rdata_q;
  assign err_o      = err_q;
  assign sram_cs_o  = cs_q;
  assign sram_oe_o  = oe_q;
  assign sram_web_o = web_q;
  assign sram_a_o   = a_q;
  assign sram_di_o  = di_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench for mem_port_responder: instance 0 uses default latencies, instance 1
// uses READ_LAT=5/WRITE_LAT=3; each has its own behavioural SRAM.
module tb_mem_port_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req [2];
  logic        read_i = 1'b0;
  logic        write_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [3:0]  web_i = 4'hF;
  logic [31:0] wdata_i = '0;

  logic        wait_w [2];
  logic [31:0] rdata_w [2];
  logic        err_w [2];
  logic        cs_w [2];
  logic        oe_w [2];
  logic [3:0]  web_w [2];
  logic [13:0] a_w [2];
  logic [31:0] di_w [2];
  logic [31:0] sdo_w [2];

  logic [1:0]  pl_en = 2'b00;
  logic [7:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int RLG = (gi == 0) ? 2 : 5;
    logic [31:0] mem [256];
    logic [7:0]  rd_a = '0;
    int          rd_cnt = 0;

    mem_port_responder #(
      .READ_LAT  ((gi == 0) ? 2 : 5),
      .WRITE_LAT ((gi == 0) ? 1 : 3)
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_i      (req[gi]),
      .read_i     (read_i),
      .write_i    (write_i),
      .addr_i     (addr_i),
      .web_i      (web_i),
      .wdata_i    (wdata_i),
      .wait_o     (wait_w[gi]),
      .rdata_o    (rdata_w[gi]),
      .err_o      (err_w[gi]),
      .sram_cs_o  (cs_w[gi]),
      .sram_oe_o  (oe_w[gi]),
      .sram_web_o (web_w[gi]),
      .sram_a_o   (a_w[gi]),
      .sram_di_o  (di_w[gi]),
      .sram_do_i  (sdo_w[gi])
    );

    // SRAM model: data is valid only in the cycle RLG cycles after the strobe.
    always @(posedge clk) begin
      if (pl_en[gi]) mem[pl_addr] <= pl_data;
      if (cs_w[gi]) begin
        rd_a   <= a_w[gi][7:0];
        rd_cnt <= 1;
        for (int b = 0; b < 4; b++) begin
          if (!web_w[gi][b]) mem[a_w[gi][7:0]][8*b +: 8] <= di_w[gi][8*b +: 8];
        end
      end else if (rd_cnt > 0 && rd_cnt < RLG) begin
        rd_cnt <= rd_cnt + 1;
      end else begin
        rd_cnt <= 0;
      end
    end

    assign sdo_w[gi] = (rd_cnt == RLG) ? mem[rd_a] : 32'h0BAD0BAD;
  end

  typedef struct {
    int          inst;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  web;
    logic [31:0] wdata;
    int          exp_wait;
    int          exp_strb;
    logic [13:0] exp_a;
    logic [3:0]  exp_sweb;
    int          exp_oe;
    logic        exp_err;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic preload(input int inst, input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en[inst] = 1'b1;
    pl_addr     = a;
    pl_data     = d;
    @(negedge clk);
    pl_en = 2'b00;
  endtask

  task automatic run_txn(input int inst, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [3:0] web,
                         input logic [31:0] wdata,
                         output int wc, output int sc, output int sk,
                         output logic [13:0] sa, output logic [3:0] sw,
                         output int oc, output logic ed, output logic [31:0] rdd,
                         output logic ea);
    bit done = 0;
    wc = 0; sc = 0; sk = -1; sa = '0; sw = 4'hF; oc = 0; ed = 1'b0; rdd = '0; ea = 1'b1;
    @(negedge clk);
    read_i = rd; write_i = wr; addr_i = addr; web_i = web; wdata_i = wdata;
    req[inst] = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (cs_w[inst]) begin
        sc++;
        if (sk < 0) begin
          sk = k; sa = a_w[inst]; sw = web_w[inst];
        end
      end
      if (oe_w[inst]) oc++;
      if (wait_w[inst]) begin
        wc++;
      end else if (k > 0) begin
        ed = err_w[inst];
        rdd = rdata_w[inst];
        done = 1;
        break;
      end
      @(negedge clk);
    end
    req[inst] = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL txn_timeout inst=%0d actual=no_done required=done", inst);
    end
    @(negedge clk);
    #1;
    ea = err_w[inst];
  endtask

  initial begin
    int wc, sc, sk, oc, k1, k2, bsc;
    logic [13:0] sa, a1, a2;
    logic [3:0]  sw;
    logic        ed, ea;
    logic [31:0] rdd;

    req[0] = 1'b0;
    req[1] = 1'b0;

    vecs[0]  = '{0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0,         4, 1, 14'h40, 4'hF, 3, 1'b0, 32'hDEADBEEF, "rd_default"};
    vecs[1]  = '{0, 1'b0, 1'b1, 32'h0000_0008, 4'hC, 32'h11223344,  2, 1, 14'h02, 4'hC, 0, 1'b0, 32'hDEADBEEF, "wr_half"};
    vecs[2]  = '{0, 1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0,         4, 1, 14'h02, 4'hF, 3, 1'b0, 32'hAAAA3344, "rd_merge"};
    vecs[3]  = '{0, 1'b1, 1'b1, 32'h0000_0100, 4'hF, 32'h0,         1, 0, 14'h00, 4'hF, 0, 1'b1, 32'hAAAA3344, "illegal_11"};
    vecs[4]  = '{0, 1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0,         1, 0, 14'h00, 4'hF, 0, 1'b1, 32'hAAAA3344, "illegal_00"};
    vecs[5]  = '{0, 1'b0, 1'b1, 32'h0000_0008, 4'hF, 32'hFFFFFFFF,  2, 1, 14'h02, 4'hF, 0, 1'b0, 32'hAAAA3344, "wr_noop"};
    vecs[6]  = '{0, 1'b1, 1'b0, 32'hABCD_0103, 4'hF, 32'h0,         4, 1, 14'h40, 4'hF, 3, 1'b0, 32'hDEADBEEF, "rd_addr_mask"};
    vecs[7]  = '{0, 1'b1, 1'b0, 32'h0000_0008, 4'hF, 32'h0,         4, 1, 14'h02, 4'hF, 3, 1'b0, 32'hAAAA3344, "rd_after_noop"};
    vecs[8]  = '{1, 1'b1, 1'b0, 32'h0000_000C, 4'hF, 32'h0,         7, 1, 14'h03, 4'hF, 6, 1'b0, 32'hCAFEF00D, "rd_lat5"};
    vecs[9]  = '{1, 1'b0, 1'b1, 32'h0000_000C, 4'h0, 32'h01020304,  4, 1, 14'h03, 4'h0, 0, 1'b0, 32'hCAFEF00D, "wr_lat3"};
    vecs[10] = '{1, 1'b1, 1'b0, 32'h0000_000C, 4'hF, 32'h0,         7, 1, 14'h03, 4'hF, 6, 1'b0, 32'h01020304, "rd_lat5_back"};
    vecs[11] = '{1, 1'b1, 1'b1, 32'h0000_000C, 4'hF, 32'h0,         1, 0, 14'h00, 4'hF, 0, 1'b1, 32'h01020304, "illegal_lat5"};

    // Reset state, with a request pending to show wait_o is forced low.
    req[0] = 1'b1; read_i = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("rst_wait%0d", i),  wait_w[i],  0);
      check($sformatf("rst_rdata%0d", i), rdata_w[i], 0);
      check($sformatf("rst_err%0d", i),   err_w[i],   0);
      check($sformatf("rst_cs%0d", i),    cs_w[i],    0);
      check($sformatf("rst_oe%0d", i),    oe_w[i],    0);
      check($sformatf("rst_web%0d", i),   web_w[i],   4'hF);
      check($sformatf("rst_a%0d", i),     a_w[i],     0);
      check($sformatf("rst_di%0d", i),    di_w[i],    0);
    end
    req[0] = 1'b0; read_i = 1'b0;
    preload(0, 8'h40, 32'hDEADBEEF);
    preload(0, 8'h02, 32'hAAAAAAAA);
    preload(0, 8'h01, 32'h55667788);
    preload(1, 8'h03, 32'hCAFEF00D);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      run_txn(vecs[i].inst, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].web, vecs[i].wdata,
              wc, sc, sk, sa, sw, oc, ed, rdd, ea);
      $display("txn %-14s inst=%0d wait=%0d strobes=%0d a=%0h web=%0h oe=%0d err=%0b rdata=%08h",
               vecs[i].name, vecs[i].inst, wc, sc, sa, sw, oc, ed, rdd);
      check({vecs[i].name, "_wait"},    wc,  vecs[i].exp_wait);
      check({vecs[i].name, "_strobes"}, sc,  vecs[i].exp_strb);
      check({vecs[i].name, "_strb_cyc"}, sk, (vecs[i].exp_strb != 0) ? 1 : -1);
      if (vecs[i].exp_strb != 0) check({vecs[i].name, "_addr"}, sa, vecs[i].exp_a);
      check({vecs[i].name, "_sweb"},    sw,  vecs[i].exp_sweb);
      check({vecs[i].name, "_oe"},      oc,  vecs[i].exp_oe);
      check({vecs[i].name, "_err"},     ed,  vecs[i].exp_err);
      check({vecs[i].name, "_rdata"},   rdd, vecs[i].exp_rdata);
      check({vecs[i].name, "_err_end"}, ea,  0);
    end

    // Back-to-back: req held through DONE, address switched to word 1.
    bsc = 0; k1 = -1; k2 = -1; a1 = '0; a2 = '0;
    @(negedge clk);
    read_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0100; req[0] = 1'b1;
    for (int k = 0; k < 15; k++) begin
      #1;
      if (cs_w[0]) begin
        bsc++;
        if (bsc == 1) begin k1 = k; a1 = a_w[0]; end
        else begin k2 = k; a2 = a_w[0]; end
      end
      if (k == 4) begin
        check("b2b_done1_wait", wait_w[0], 0);
        check("b2b_done1_rdata", rdata_w[0], 32'hDEADBEEF);
        addr_i = 32'h0000_0004;
      end
      if (k == 5) check("b2b_accept_wait", wait_w[0], 1);
      if (k == 9) begin
        check("b2b_done2_wait", wait_w[0], 0);
        check("b2b_done2_rdata", rdata_w[0], 32'h55667788);
        req[0] = 1'b0;
      end
      @(negedge clk);
    end
    $display("txn b2b inst=0 strobes=%0d cyc=%0d,%0d a=%0h,%0h", bsc, k1, k2, a1, a2);
    check("b2b_strobes", bsc, 2);
    check("b2b_cyc1", k1, 1);
    check("b2b_cyc2", k2, 6);
    check("b2b_a1", a1, 14'h40);
    check("b2b_a2", a2, 14'h01);

    // Reset asserted in C2 of a read.
    bsc = 0;
    @(negedge clk);
    read_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0008; req[0] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      #1;
      if (k >= 3 && cs_w[0]) bsc++;
      if (k == 2) begin
        rst_n = 1'b0;
        req[0] = 1'b0;
      end
      if (k == 3) begin
        check("mrst_wait", wait_w[0], 0);
        check("mrst_rdata", rdata_w[0], 0);
        check("mrst_oe", oe_w[0], 0);
        check("mrst_a", a_w[0], 0);
        rst_n = 1'b1;
      end
      @(negedge clk);
    end
    $display("txn midreset inst=0 strobes_after=%0d", bsc);
    check("mrst_no_strobe", bsc, 0);
    run_txn(0, 1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'h0, wc, sc, sk, sa, sw, oc, ed, rdd, ea);
    $display("txn post_reset inst=0 wait=%0d strobes=%0d rdata=%08h", wc, sc, rdd);
    check("post_rst_wait", wc, 4);
    check("post_rst_strobes", sc, 1);
    check("post_rst_rdata", rdd, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
